// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the data-memory load/store unit.
// Holds the access-size encoding, the LSU FSM state type, the RAM byte
// count and the byte-enable helper used when a store is accepted.
package lsu_pkg;

  localparam int RAM_BYTES = 4;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RSP     = 2'd3
  } state_e;

  // Byte lanes touched by an access of the given size at byte offset off.
  function automatic logic [RAM_BYTES-1:0] byte_en_for(size_e size, logic [1:0] off);
    logic [RAM_BYTES-1:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << off;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load data alignment and extension.
// Ports:
//   dout          raw 32-bit RAM word
//   off           byte offset of the access within the word
//   size          access size (byte / half / word)
//   load_unsigned zero-extend when 1, sign-extend when 0
//   data          aligned, extended result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] dout,
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        load_unsigned,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = dout >> {off, 3'b000};
    case (size)
      SZ_B:    data = {{24{shifted[7] & ~load_unsigned}}, shifted[7:0]};
      SZ_H:    data = {{16{shifted[15] & ~load_unsigned}}, shifted[15:0]};
      SZ_W:    data = shifted;
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: RV32 load/store unit driving one port of a byte-enabled,
// 1-cycle registered-read data RAM.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   req_valid/req_ready                 request handshake (ready only when idle)
//   req_we/req_size/req_unsigned        access kind
//   req_addr/req_wdata                  byte address and LSB-justified store data
//   rsp_valid/rsp_ready                 response handshake
//   rsp_rdata/rsp_err                   extended load data, error flag
//   ram_addr/ram_din/ram_we/ram_byte_en RAM port drive
//   ram_dout                            RAM read data, valid one cycle after ram_addr
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 512,
  parameter int RAM_AW    = $clog2(RAM_DEPTH-1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [RAM_AW-1:0]    ram_addr,
  output logic [RAM_WIDTH-1:0] ram_din,
  output logic                 ram_we,
  output logic [RAM_BYTES-1:0] ram_byte_en,
  input  logic [RAM_WIDTH-1:0] ram_dout
);

  state_e      state, next_state;
  size_e       size_q;
  logic        unsigned_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic        misaligned;
  logic        out_of_range;
  logic        acc_err;
  logic        accept;
  logic [31:0] store_din;
  logic [31:0] load_data;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RSP);
  assign accept    = req_valid && req_ready;

  // Size 11 is folded into the misaligned term so all rejects share one path.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
    out_of_range = {2'b00, req_addr[31:2]} >= 32'(RAM_DEPTH);
    acc_err      = misaligned || out_of_range;
  end

  // Store data is replicated across lanes; byte enables pick the live lane.
  always_comb begin
    case (size_e'(req_size))
      SZ_B:    store_din = {4{req_wdata[7:0]}};
      SZ_H:    store_din = {2{req_wdata[15:0]}};
      default: store_din = req_wdata;
    endcase
  end

  lsu_load_align u_align (
    .dout          (ram_dout),
    .off           (off_q),
    .size          (size_q),
    .load_unsigned (unsigned_q),
    .data          (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = acc_err ? RSP : ACCESS;
      ACCESS:  next_state = we_q ? RSP : CAPTURE;
      CAPTURE: next_state = RSP;
      RSP:     if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ram_we is set only on a clean accepted store, so it is high for exactly
  // the ACCESS cycle; a reset landing on that cycle cannot recall the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      size_q      <= SZ_B;
      unsigned_q  <= 1'b0;
      off_q       <= 2'b00;
      we_q        <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= 32'h0;
      ram_we      <= 1'b0;
      ram_byte_en <= '0;
      ram_addr    <= '0;
      ram_din     <= '0;
    end else begin
      ram_we <= 1'b0;
      if (accept) begin
        size_q     <= size_e'(req_size);
        unsigned_q <= req_unsigned;
        off_q      <= req_addr[1:0];
        we_q       <= req_we;
        rsp_rdata  <= 32'h0;
        if (acc_err) begin
          rsp_err <= 1'b1;
        end else begin
          ram_addr    <= req_addr[RAM_AW+1:2];
          ram_din     <= store_din;
          ram_we      <= req_we;
          ram_byte_en <= req_we ? byte_en_for(size_e'(req_size), req_addr[1:0]) : '0;
        end
      end
      if (state == CAPTURE) rsp_rdata <= load_data;
      if (state == RSP && rsp_ready) rsp_err <= 1'b0;
    end
  end

endmodule
